hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 16-bit five-stage core.
- Generates the `Pause` input of the ID/EX register, PC/IF-ID stall and flush controls, and arbitration of the single shared memory port between instruction fetch and data access.
- Resolves three hazards:
  - load-use data hazards, by inserting a bubble and replaying the instruction;
  - taken jumps and branches, by flushing;
  - structural conflicts on memory, by stalling with a counted wait.

Parameters:
- MEM_WAIT, 2, number of cycles a data access holds the memory port (1..15).
- IDX_W, 4, register index width.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous active-low reset.
- IdRead1Use  input  1  ID instruction reads source 1.
- IdRead2Use  input  1  ID instruction reads source 2.
- IdReadIdx1  input  IDX_W  ID source-1 register index.
- IdReadIdx2  input  IDX_W  ID source-2 register index.
- ExMemRead  input  1  MemRead1 from ID/EX (a load is in EX).
- ExRegWrite  input  1  RegWrite1 from ID/EX.
- ExWriteIdx  input  IDX_W  RegWriteIndex1 from ID/EX.
- BranchTaken  input  1  EX resolved a taken jump or branch this cycle.
- MemReq  input  1  MEM stage holds a data load or store this cycle.
- Pause  output  1  to ID/EX: insert bubble and capture the ID instruction.
- PcStall  output  1  hold PC.
- IfIdStall  output  1  hold IF/ID.
- IfIdFlush  output  1  load a NOP into IF/ID.
- IdExFlush  output  1  force an ID/EX bubble (flush path).
- PipeHold  output  1  hold EX/MEM and MEM/WB during a data wait.
- MemSelData  output  1  1 = memory port to data, 0 = instruction fetch.

Behaviour:
- State register values (held in config.v): RUN, REPLAY, MEM_WAIT. The counter `wcnt` is 4 bits.
- Reset (Rst low, asynchronous):
  - state = RUN, wcnt = 0;
  - all outputs 0 while Rst is low and in the first RUN cycle with no hazard.
- All outputs are combinational from state plus inputs (Mealy). State and wcnt change on the rising edge of Clk only.
- Load-use hit (lu): ExMemRead & ExRegWrite & ((IdRead1Use & IdReadIdx1 == ExWriteIdx) | (IdRead2Use & IdReadIdx2 == ExWriteIdx)).
- RUN, evaluated in priority order; the first match applies:
  1. MemReq: MemSelData=1, PcStall=1, IfIdStall=1, PipeHold=1, Pause=0. If MEM_WAIT > 1, go to MEM_WAIT with wcnt = MEM_WAIT-1. Otherwise stay in RUN and release the port next cycle.
  2. BranchTaken: IfIdFlush=1, IdExFlush=1. Stay in RUN. A load-use hit in the same cycle is ignored because its instruction is flushed.
  3. lu: Pause=1 for exactly this cycle, so ID/EX captures the ID instruction and emits a bubble. PcStall=0 and IfIdStall=0 so fetch advances. Go to REPLAY.
  4. Otherwise all outputs 0.
- REPLAY (one cycle): ID/EX is replaying its captured instruction and ignores ID inputs.
  - PcStall=1 and IfIdStall=1, so the next instruction is not lost. Pause=0.
  - Go to RUN.
  - If MemReq is asserted in REPLAY: also MemSelData=1 and PipeHold=1, and go to MEM_WAIT with wcnt = MEM_WAIT-1 (or to RUN if MEM_WAIT = 1).
  - BranchTaken in REPLAY: IfIdFlush=1 and IdExFlush=1 in addition; stall still applies; go to RUN.
- MEM_WAIT:
  - MemSelData=1, PcStall=1, IfIdStall=1, PipeHold=1. All other outputs 0; BranchTaken and lu are ignored.
  - wcnt decrements each cycle; when wcnt == 1, go to RUN.
  - Total port occupancy is exactly MEM_WAIT cycles, counting the entry cycle.
- Pause is never asserted on two consecutive cycles. Pause and IdExFlush are never both 1.
- Reset asserted mid-MEM_WAIT or mid-REPLAY aborts immediately to RUN with all outputs 0.
- Register index 0 gets no special treatment; every index compares.

Decomposition:
- State encodings and the MEM_WAIT default are `define entries in config.v, alongside the existing ALU and branch codes.
- One natural sub-module: hazard_detect, a purely combinational load-use comparator producing lu. Instantiated once.

Test Plan:
- Load-use: EX holds a load to R3, ID reads R3 via source 2.
  - Cycle 0: Pause=1, PcStall=0.
  - Cycle 1: PcStall=IfIdStall=1, Pause=0.
  - Cycle 2: all outputs 0.
- No-hazard negatives:
  - Load to R3 with ID reading R4 gives no Pause.
  - A non-load write to R3 (ExMemRead=0) gives no Pause.
- Branch priority: BranchTaken=1 and lu=1 in the same cycle.
  - IfIdFlush=IdExFlush=1, Pause=0.
  - Next cycle: no stall.
- Memory wait with MEM_WAIT=3: MemReq pulsed for one cycle.
  - MemSelData, PcStall and PipeHold are 1 for exactly 3 cycles, then 0.
  - BranchTaken raised during the 2nd cycle has no effect.
- MEM_WAIT=1: MemReq on two consecutive cycles.
  - MemSelData=1 both cycles; state remains RUN.
- Reset while in MEM_WAIT with wcnt=1: all outputs 0 immediately; after release, a load-use hit produces Pause on the first cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the five-stage core hazard controller.
// Controller states, control-word layout and the memory-wait counter load helper.
package hazard_ctrl_pkg;

    localparam int MEM_WAIT_DEFAULT = 2;
    localparam int IDX_W_DEFAULT    = 4;
    localparam int WCNT_W           = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REPLAY   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pause;
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_hold;
        logic mem_sel_data;
    } hz_ctl_t;

    localparam hz_ctl_t HZ_CTL_IDLE = '0;

    // The entry cycle counts as the first cycle of port occupancy.
    function automatic logic [WCNT_W-1:0] wait_load(input int mem_wait);
        return WCNT_W'(mem_wait - 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller.
// MemReq is a level request held by the MEM stage; MemSelData is the grant and PipeHold keeps MEM/WB frozen until the grant drops.
interface hazard_ctrl_if #(
    parameter int IDX_W = 4
);

    logic             IdRead1Use;
    logic             IdRead2Use;
    logic [IDX_W-1:0] IdReadIdx1;
    logic [IDX_W-1:0] IdReadIdx2;
    logic             ExMemRead;
    logic             ExRegWrite;
    logic [IDX_W-1:0] ExWriteIdx;
    logic             BranchTaken;
    logic             MemReq;

    logic             Pause;
    logic             PcStall;
    logic             IfIdStall;
    logic             IfIdFlush;
    logic             IdExFlush;
    logic             PipeHold;
    logic             MemSelData;

    modport master (
        output IdRead1Use, IdRead2Use, IdReadIdx1, IdReadIdx2,
        output ExMemRead, ExRegWrite, ExWriteIdx, BranchTaken, MemReq,
        input  Pause, PcStall, IfIdStall, IfIdFlush, IdExFlush, PipeHold, MemSelData
    );

    modport slave (
        input  IdRead1Use, IdRead2Use, IdReadIdx1, IdReadIdx2,
        input  ExMemRead, ExRegWrite, ExWriteIdx, BranchTaken, MemReq,
        output Pause, PcStall, IfIdStall, IfIdFlush, IdExFlush, PipeHold, MemSelData
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an ID source that a load in EX is about to write.
// Register 0 is compared like any other index.
module hazard_detect #(
    parameter int IDX_W = 4
) (
    input  logic             read1_use,
    input  logic             read2_use,
    input  logic [IDX_W-1:0] read_idx1,
    input  logic [IDX_W-1:0] read_idx2,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [IDX_W-1:0] ex_write_idx,
    output logic             lu
);

    logic hit1;
    logic hit2;

    assign hit1 = read1_use && (read_idx1 == ex_write_idx);
    assign hit2 = read2_use && (read_idx2 == ex_write_idx);
    assign lu   = ex_mem_read && ex_reg_write && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use replay, taken-branch flush and shared memory port arbitration.
// Outputs are Mealy from state plus inputs and are forced low while Rst is asserted.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEFAULT,
    parameter int IDX_W    = IDX_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    hazard_ctrl_if.slave      hz,
    output state_t            DbgState,
    output logic [WCNT_W-1:0] DbgWcnt
);

    localparam bit                MW_MULTI  = (MEM_WAIT > 1);
    localparam logic [WCNT_W-1:0] WAIT_INIT = wait_load(MEM_WAIT);

    state_t            state;
    state_t            state_n;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_n;
    hz_ctl_t           ctl;
    logic              lu;

    hazard_detect #(
        .IDX_W(IDX_W)
    ) u_detect (
        .read1_use    (hz.IdRead1Use),
        .read2_use    (hz.IdRead2Use),
        .read_idx1    (hz.IdReadIdx1),
        .read_idx2    (hz.IdReadIdx2),
        .ex_mem_read  (hz.ExMemRead),
        .ex_reg_write (hz.ExRegWrite),
        .ex_write_idx (hz.ExWriteIdx),
        .lu           (lu)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_RUN;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        ctl     = HZ_CTL_IDLE;
        state_n = state;
        wcnt_n  = wcnt;
        unique case (state)
            ST_RUN: begin
                if (hz.MemReq) begin
                    ctl.mem_sel_data = 1'b1;
                    ctl.pc_stall     = 1'b1;
                    ctl.if_id_stall  = 1'b1;
                    ctl.pipe_hold    = 1'b1;
                    if (MW_MULTI) begin
                        state_n = ST_MEM_WAIT;
                        wcnt_n  = WAIT_INIT;
                    end
                end else if (hz.BranchTaken) begin
                    // A coincident load-use hit belongs to an instruction being flushed.
                    ctl.if_id_flush = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                end else if (lu) begin
                    ctl.pause = 1'b1;
                    state_n   = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                // ID/EX replays its captured instruction; hold fetch so the next one survives.
                ctl.pc_stall    = 1'b1;
                ctl.if_id_stall = 1'b1;
                state_n         = ST_RUN;
                if (hz.BranchTaken) begin
                    ctl.if_id_flush = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                end
                if (hz.MemReq) begin
                    ctl.mem_sel_data = 1'b1;
                    ctl.pipe_hold    = 1'b1;
                    if (MW_MULTI) begin
                        state_n = ST_MEM_WAIT;
                        wcnt_n  = WAIT_INIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                ctl.mem_sel_data = 1'b1;
                ctl.pc_stall     = 1'b1;
                ctl.if_id_stall  = 1'b1;
                ctl.pipe_hold    = 1'b1;
                wcnt_n           = wcnt - WCNT_W'(1);
                if (wcnt <= WCNT_W'(1)) begin
                    state_n = ST_RUN;
                    wcnt_n  = '0;
                end
            end
            default: begin
                state_n = ST_RUN;
                wcnt_n  = '0;
            end
        endcase
    end

    assign hz.Pause      = Rst && ctl.pause;
    assign hz.PcStall    = Rst && ctl.pc_stall;
    assign hz.IfIdStall  = Rst && ctl.if_id_stall;
    assign hz.IfIdFlush  = Rst && ctl.if_id_flush;
    assign hz.IdExFlush  = Rst && ctl.id_ex_flush;
    assign hz.PipeHold   = Rst && ctl.pipe_hold;
    assign hz.MemSelData = Rst && ctl.mem_sel_data;

    assign DbgState = state;
    assign DbgWcnt  = wcnt;

    // A bubble never follows a bubble, and a bubble is never also a flush.
    assert property (@(posedge Clk) disable iff (!Rst) hz.Pause |=> !hz.Pause);
    assert property (@(posedge Clk) disable iff (!Rst) !(hz.Pause && hz.IdExFlush));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl with MEM_WAIT=3 and MEM_WAIT=1 instances sharing stimulus.
// Expected control words come from a cycle-occupancy reference model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int IDX_W = 4;
    localparam int W     = 9;

    typedef struct packed {
        logic             rst;
        logic             r1u;
        logic [IDX_W-1:0] i1;
        logic             r2u;
        logic [IDX_W-1:0] i2;
        logic             exmr;
        logic             exrw;
        logic [IDX_W-1:0] exwi;
        logic             br;
        logic             memreq;
    } stim_t;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    hazard_ctrl_if #(.IDX_W(IDX_W)) if_a ();
    hazard_ctrl_if #(.IDX_W(IDX_W)) if_b ();

    state_t     dbg_state_a;
    state_t     dbg_state_b;
    logic [3:0] dbg_wcnt_a;
    logic [3:0] dbg_wcnt_b;

    hazard_ctrl #(.MEM_WAIT(3), .IDX_W(IDX_W)) dut_a (
        .Clk(Clk), .Rst(Rst), .hz(if_a), .DbgState(dbg_state_a), .DbgWcnt(dbg_wcnt_a)
    );
    hazard_ctrl #(.MEM_WAIT(1), .IDX_W(IDX_W)) dut_b (
        .Clk(Clk), .Rst(Rst), .hz(if_b), .DbgState(dbg_state_b), .DbgWcnt(dbg_wcnt_b)
    );

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int mon_cyc = 0;

    // Reference model: remaining data-port cycles and a pending replay slot per instance.
    int busy   [2];
    bit replay [2];

    function automatic int mw_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    // Returns {Pause,PcStall,IfIdStall,IfIdFlush,IdExFlush,PipeHold,MemSelData,state}.
    function automatic logic [W-1:0] model_step(input int k, input stim_t s);
        logic [6:0] o;
        state_t     st;
        logic       lu;
        o  = '0;
        lu = s.exmr && s.exrw && ((s.r1u && s.i1 == s.exwi) || (s.r2u && s.i2 == s.exwi));
        if (!s.rst) begin
            busy[k]   = 0;
            replay[k] = 1'b0;
            return {7'b0, ST_RUN};
        end
        st = (busy[k] > 0) ? ST_MEM_WAIT : (replay[k] ? ST_REPLAY : ST_RUN);
        if (busy[k] > 0) begin
            o = 7'b0110011;
            busy[k]--;
        end else if (replay[k]) begin
            replay[k] = 1'b0;
            o = 7'b0110000;
            if (s.br) o = o | 7'b0001100;
            if (s.memreq) begin
                o = o | 7'b0000011;
                busy[k] = mw_of(k) - 1;
            end
        end else if (s.memreq) begin
            o = 7'b0110011;
            busy[k] = mw_of(k) - 1;
        end else if (s.br) begin
            o = 7'b0001100;
        end else if (lu) begin
            o = 7'b1000000;
            replay[k] = 1'b1;
        end
        return {o, st};
    endfunction

    function automatic stim_t mk(input bit rst, input bit r1u, input int i1, input bit r2u, input int i2,
                                 input bit exmr, input bit exrw, input int exwi, input bit br, input bit mr);
        stim_t s;
        s.rst = rst;   s.r1u = r1u;   s.i1 = IDX_W'(i1);  s.r2u = r2u;  s.i2 = IDX_W'(i2);
        s.exmr = exmr; s.exrw = exrw; s.exwi = IDX_W'(exwi); s.br = br; s.memreq = mr;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst    = ($urandom_range(0, 49) != 0);
        s.r1u    = 1'($urandom_range(0, 1));
        s.r2u    = 1'($urandom_range(0, 1));
        s.i1     = IDX_W'($urandom_range(0, 3));
        s.i2     = IDX_W'($urandom_range(0, 3));
        s.exmr   = ($urandom_range(0, 2) != 0);
        s.exrw   = ($urandom_range(0, 3) != 0);
        s.exwi   = IDX_W'($urandom_range(0, 3));
        s.br     = ($urandom_range(0, 5) == 0);
        s.memreq = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        Rst              = s.rst;
        if_a.IdRead1Use  = s.r1u;   if_b.IdRead1Use  = s.r1u;
        if_a.IdRead2Use  = s.r2u;   if_b.IdRead2Use  = s.r2u;
        if_a.IdReadIdx1  = s.i1;    if_b.IdReadIdx1  = s.i1;
        if_a.IdReadIdx2  = s.i2;    if_b.IdReadIdx2  = s.i2;
        if_a.ExMemRead   = s.exmr;  if_b.ExMemRead   = s.exmr;
        if_a.ExRegWrite  = s.exrw;  if_b.ExRegWrite  = s.exrw;
        if_a.ExWriteIdx  = s.exwi;  if_b.ExWriteIdx  = s.exwi;
        if_a.BranchTaken = s.br;    if_b.BranchTaken = s.br;
        if_a.MemReq      = s.memreq; if_b.MemReq     = s.memreq;
    endtask

    task automatic drive(input stim_t s);
        @(posedge Clk);
        #1;
        apply(s);
        exp_a_q.push_back(model_step(0, s));
        exp_b_q.push_back(model_step(1, s));
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, mon_cyc, got, want);
        end
    endtask

    always @(negedge Clk) begin
        if (exp_a_q.size() > 0) begin
            check("dut_a(MW=3)",
                  {if_a.Pause, if_a.PcStall, if_a.IfIdStall, if_a.IfIdFlush, if_a.IdExFlush,
                   if_a.PipeHold, if_a.MemSelData, dbg_state_a},
                  exp_a_q.pop_front());
        end
        if (exp_b_q.size() > 0) begin
            check("dut_b(MW=1)",
                  {if_b.Pause, if_b.PcStall, if_b.IfIdStall, if_b.IfIdFlush, if_b.IdExFlush,
                   if_b.PipeHold, if_b.MemSelData, dbg_state_b},
                  exp_b_q.pop_front());
        end
        mon_cyc++;
    end

    initial begin
        stim_t idle;
        stim_t lu3;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu3  = mk(1, 1, 5, 1, 3, 1, 1, 3, 0, 0);
        busy   = '{0, 0};
        replay = '{0, 0};
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset, then a quiet cycle.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(mk(0, 0, 0, 1, 3, 1, 1, 3, 1, 0));
        drive(idle);
        // Load-use on source 2, replay cycle (ID inputs ignored), then clear.
        drive(lu3);
        drive(lu3);
        drive(idle);
        // Negatives: different index, and a non-load writer.
        drive(mk(1, 1, 4, 1, 4, 1, 1, 3, 0, 0));
        drive(mk(1, 0, 0, 1, 3, 0, 1, 3, 0, 0));
        // Register 0 compares like any other.
        drive(mk(1, 1, 0, 0, 7, 1, 1, 0, 0, 0));
        drive(idle);
        // Branch outranks a coincident load-use hit.
        drive(mk(1, 0, 0, 1, 3, 1, 1, 3, 1, 0));
        drive(idle);
        // Single MemReq pulse with a branch in the second cycle.
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(mk(1, 0, 0, 1, 3, 1, 1, 3, 1, 0));
        drive(idle);
        drive(idle);
        drive(idle);
        // Back-to-back MemReq.
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(idle);
        drive(idle);
        drive(idle);
        drive(idle);
        // Reset on the last wait cycle, then a load-use hit right after release.
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(idle);
        drive(mk(0, 1, 3, 0, 0, 1, 1, 3, 0, 1));
        drive(lu3);
        drive(idle);
        drive(idle);
        // Reset in the middle of a replay.
        drive(lu3);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        drive(idle);
        // Replay cycle with a branch and a memory request together.
        drive(lu3);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        drive(idle);
        drive(idle);
        drive(idle);

        for (int i = 0; i < 800; i++) begin
            drive(rand_stim());
        end
        drive(idle);

        @(negedge Clk);
        #1;
        n_cmp++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d/%0d pending want=0/0", exp_a_q.size(), exp_b_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
